// File: rtl/ecc_point_pkg.sv
// ecc_point_pkg: field-op codes, register-file indices, microinstruction format, sequence bounds, FSM states
package ecc_point_pkg;
    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;
    localparam int RF_N = 10;
    localparam logic [3:0] R_X1 = 4'd0;
    localparam logic [3:0] R_Y1 = 4'd1;
    localparam logic [3:0] R_X2 = 4'd2;
    localparam logic [3:0] R_Y2 = 4'd3;
    localparam logic [3:0] R_A  = 4'd4;
    localparam logic [3:0] R_L  = 4'd5;
    localparam logic [3:0] R_T0 = 4'd6;
    localparam logic [3:0] R_T1 = 4'd7;
    localparam logic [3:0] R_X3 = 4'd8;
    localparam logic [3:0] R_Y3 = 4'd9;
    localparam int UI_W = 14;
    localparam logic [4:0] ADD_PC  = 5'd0;
    localparam logic [4:0] ADD_LEN = 5'd9;
    localparam logic [4:0] DBL_PC  = 5'd9;
    localparam logic [4:0] DBL_LEN = 5'd12;
    localparam logic [4:0] ADD_END = ADD_PC + ADD_LEN - 5'd1;
    localparam logic [4:0] DBL_END = DBL_PC + DBL_LEN - 5'd1;
    typedef struct packed {
        logic [1:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] d;
    } uinst_t;
    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ISSUE, S_WAIT, S_FINISH} state_t;
endpackage

// File: rtl/ecc_point_ucode_rom.sv
// ecc_point_ucode_rom: pc -> microinstruction {op,srcA,srcB,dst}; add sequence at 0..8, double at 9..20
module ecc_point_ucode_rom
    import ecc_point_pkg::*;
(
    input  logic [4:0] pc,
    output uinst_t     ui
);
    always_comb begin
        ui = '0;
        case (pc)
            5'd0:  ui = '{OP_SUB, R_Y2, R_Y1, R_T0};
            5'd1:  ui = '{OP_SUB, R_X2, R_X1, R_T1};
            5'd2:  ui = '{OP_DIV, R_T0, R_T1, R_L};
            5'd3:  ui = '{OP_MUL, R_L,  R_L,  R_T0};
            5'd4:  ui = '{OP_SUB, R_T0, R_X1, R_T0};
            5'd5:  ui = '{OP_SUB, R_T0, R_X2, R_X3};
            5'd6:  ui = '{OP_SUB, R_X1, R_X3, R_T1};
            5'd7:  ui = '{OP_MUL, R_L,  R_T1, R_T1};
            5'd8:  ui = '{OP_SUB, R_T1, R_Y1, R_Y3};
            5'd9:  ui = '{OP_MUL, R_X1, R_X1, R_T0};
            5'd10: ui = '{OP_ADD, R_T0, R_T0, R_T1};
            5'd11: ui = '{OP_ADD, R_T1, R_T0, R_T0};
            5'd12: ui = '{OP_ADD, R_T0, R_A,  R_T0};
            5'd13: ui = '{OP_ADD, R_Y1, R_Y1, R_T1};
            5'd14: ui = '{OP_DIV, R_T0, R_T1, R_L};
            5'd15: ui = '{OP_MUL, R_L,  R_L,  R_T1};
            5'd16: ui = '{OP_SUB, R_T1, R_X1, R_T1};
            5'd17: ui = '{OP_SUB, R_T1, R_X1, R_X3};
            5'd18: ui = '{OP_SUB, R_X1, R_X3, R_T0};
            5'd19: ui = '{OP_MUL, R_L,  R_T0, R_T0};
            5'd20: ui = '{OP_SUB, R_T0, R_Y1, R_Y3};
            default: ui = '0;
        endcase
    end
endmodule

// File: rtl/ecc_point_ctrl.sv
// ecc_point_ctrl: affine EC point add/double sequencer; request (i_start,i_dbl,operands) in, result (o_x3,o_y3,o_inf3,o_done) out, field-unit (o_fu_*, i_fu_*) side
module ecc_point_ctrl
    import ecc_point_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_dbl,
    input  logic [WIDTH-1:0] i_x1,
    input  logic [WIDTH-1:0] i_y1,
    input  logic [WIDTH-1:0] i_x2,
    input  logic [WIDTH-1:0] i_y2,
    input  logic [WIDTH-1:0] i_a,
    input  logic             i_inf1,
    input  logic             i_inf2,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_x3,
    output logic [WIDTH-1:0] o_y3,
    output logic             o_inf3,
    output logic [1:0]       o_fu_op,
    output logic [WIDTH-1:0] o_fu_a,
    output logic [WIDTH-1:0] o_fu_b,
    output logic             o_fu_start,
    input  logic [WIDTH-1:0] i_fu_result,
    input  logic             i_fu_done
);
    logic [WIDTH-1:0] rf [0:RF_N-1];
    state_t state;
    logic [4:0] pc;
    logic dbl, inf1, inf2;
    uinst_t ui;
    logic act, cap, last, eqx, eqy, y0, sp, sp_inf;
    logic [4:0] sp_pc;
    logic [WIDTH-1:0] sp_x, sp_y;

    ecc_point_ucode_rom u_rom (.pc(pc), .ui(ui));

    // add/sub results are captured in the issue cycle itself; mul/div wait for i_fu_done
    always_comb begin
        act = state == S_ISSUE || state == S_WAIT;
        cap = (state == S_ISSUE && !ui.op[1]) || (state == S_WAIT && i_fu_done);
        last = pc == ADD_END || pc == DBL_END;
        eqx = rf[R_X1] == rf[R_X2];
        eqy = rf[R_Y1] == rf[R_Y2];
        y0 = rf[R_Y1] == '0;
        sp = inf1 || (dbl ? y0 : (inf2 || (eqx && !eqy)));
        // only meaningful when sp is set: a non-inf1 add special case is inf unless it was the inf2 pass-through
        sp_inf = inf1 ? (dbl || inf2) : (dbl ? y0 : !inf2);
        sp_x = sp_inf ? '0 : (inf1 ? rf[R_X2] : rf[R_X1]);
        sp_y = sp_inf ? '0 : (inf1 ? rf[R_Y2] : rf[R_Y1]);
        sp_pc = (dbl || eqx) ? DBL_PC : ADD_PC;
    end

    // fu operands come straight from the register file, which is untouched while waiting, so they stay stable
    assign o_fu_start = state == S_ISSUE;
    assign o_fu_op = act ? ui.op : '0;
    assign o_fu_a = act ? rf[ui.a] : '0;
    assign o_fu_b = act ? rf[ui.b] : '0;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= S_IDLE;
            pc <= '0;
            dbl <= 1'b0;
            inf1 <= 1'b0;
            inf2 <= 1'b0;
            for (int i = 0; i < RF_N; i++) rf[i] <= '0;
            o_busy <= 1'b0;
            o_done <= 1'b0;
            o_x3 <= '0;
            o_y3 <= '0;
            o_inf3 <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (i_start) begin
                    rf[R_X1] <= i_x1;
                    rf[R_Y1] <= i_y1;
                    rf[R_X2] <= i_x2;
                    rf[R_Y2] <= i_y2;
                    rf[R_A] <= i_a;
                    dbl <= i_dbl;
                    inf1 <= i_inf1;
                    inf2 <= i_inf2;
                    o_busy <= 1'b1;
                    state <= S_CHECK;
                end
                S_CHECK: if (sp) begin
                    o_x3 <= sp_x;
                    o_y3 <= sp_y;
                    o_inf3 <= sp_inf;
                    o_done <= 1'b1;
                    state <= S_FINISH;
                end else begin
                    pc <= sp_pc;
                    state <= S_ISSUE;
                end
                S_ISSUE, S_WAIT: if (cap) begin
                    rf[ui.d] <= i_fu_result;
                    if (last) begin
                        // forward the final write, which lands in the same edge
                        o_x3 <= ui.d == R_X3 ? i_fu_result : rf[R_X3];
                        o_y3 <= ui.d == R_Y3 ? i_fu_result : rf[R_Y3];
                        o_inf3 <= 1'b0;
                        o_done <= 1'b1;
                        state <= S_FINISH;
                    end else begin
                        pc <= pc + 5'd1;
                        state <= S_ISSUE;
                    end
                end else if (state == S_ISSUE) state <= S_WAIT;
                S_FINISH: begin
                    o_done <= 1'b0;
                    o_busy <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ecc_point_ctrl.sv
// tb_ecc_point_ctrl: directed vectors against a mod-17 field-unit model (curve a=2)
module tb_ecc_point_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0, dbl = 1'b0, inf1 = 1'b0, inf2 = 1'b0;
    logic [31:0] x1 = '0, y1 = '0, x2 = '0, y2 = '0, ca = 32'd2;
    logic busy, done, inf3, fu_start, fu_done;
    logic [31:0] x3, y3, fu_a, fu_b, fu_res;
    logic [1:0] fu_op;
    int cnt = 0, starts = 0, stab_err = 0, vecs = 0, errs = 0;
    logic [31:0] la = '0, lb = '0;

    ecc_point_ctrl #(.WIDTH(32)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_dbl(dbl),
        .i_x1(x1), .i_y1(y1), .i_x2(x2), .i_y2(y2), .i_a(ca),
        .i_inf1(inf1), .i_inf2(inf2),
        .o_busy(busy), .o_done(done), .o_x3(x3), .o_y3(y3), .o_inf3(inf3),
        .o_fu_op(fu_op), .o_fu_a(fu_a), .o_fu_b(fu_b), .o_fu_start(fu_start),
        .i_fu_result(fu_res), .i_fu_done(fu_done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] fop(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        r = '0;
        case (op)
            2'd0: r = (a + b) % 17;
            2'd1: r = (a + 17 - b) % 17;
            2'd2: r = (a * b) % 17;
            default: for (int i = 1; i < 17; i++) if ((b * i) % 17 == 1) r = (a * i) % 17;
        endcase
        return r;
    endfunction

    assign fu_res = fop(fu_op, fu_a, fu_b);
    assign fu_done = cnt == 1;

    always @(posedge clk or negedge rst)
        if (!rst) cnt <= 0;
        else if (fu_start && fu_op[1]) cnt <= 3;
        else if (cnt != 0) cnt <= cnt - 1;

    always @(posedge clk) begin
        if (fu_start) begin
            starts <= starts + 1;
            la <= fu_a;
            lb <= fu_b;
        end else if (busy && cnt != 0 && (fu_a != la || fu_b != lb)) stab_err <= stab_err + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic run(input string nm, input logic d, input int px1, input int py1, input int px2, input int py2,
                       input logic i1, input logic i2, input int ex, input int ey, input logic ei, input int ecyc, input int est);
        int cyc, s0;
        @(negedge clk);
        dbl = d; x1 = px1; y1 = py1; x2 = px2; y2 = py2; inf1 = i1; inf2 = i2;
        start = 1'b1;
        s0 = starts;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        chk({nm, ".done"}, done, 1);
        chk({nm, ".busy"}, busy, 1);
        chk({nm, ".x3"}, x3, ex);
        chk({nm, ".y3"}, y3, ey);
        chk({nm, ".inf3"}, inf3, ei);
        chk({nm, ".cycles"}, cyc, ecyc);
        chk({nm, ".fu_starts"}, starts - s0, est);
        @(negedge clk);
        chk({nm, ".done_pulse"}, done, 0);
        chk({nm, ".busy_off"}, busy, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.x3", x3, 0);
        chk("rst.y3", y3, 0);
        chk("rst.inf3", inf3, 0);
        chk("rst.fu_start", fu_start, 0);
        chk("rst.fu_op", fu_op, 0);
        rst = 1'b1;
        run("dbl51", 1'b1, 5, 1, 0, 0, 1'b0, 1'b0, 6, 3, 1'b0, 26, 12);
        run("add", 1'b0, 5, 1, 6, 3, 1'b0, 1'b0, 10, 6, 1'b0, 20, 9);
        chk("wait.stable", stab_err, 0);
        run("add_neg", 1'b0, 5, 1, 5, 16, 1'b0, 1'b0, 0, 0, 1'b1, 2, 0);
        run("add_same", 1'b0, 5, 1, 5, 1, 1'b0, 1'b0, 6, 3, 1'b0, 26, 12);
        run("dbl_y0", 1'b1, 3, 0, 0, 0, 1'b0, 1'b0, 0, 0, 1'b1, 2, 0);
        run("add_inf1", 1'b0, 5, 1, 6, 3, 1'b1, 1'b0, 6, 3, 1'b0, 2, 0);
        run("add_inf2", 1'b0, 5, 1, 6, 3, 1'b0, 1'b1, 5, 1, 1'b0, 2, 0);
        @(negedge clk);
        dbl = 1'b1; x1 = 5; y1 = 1; inf1 = 1'b0; inf2 = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 50 && cnt == 0; i++) @(negedge clk);
        chk("mid.reach_wait", cnt != 0, 1);
        #2 rst = 1'b0;
        #1;
        chk("mid.busy", busy, 0);
        chk("mid.done", done, 0);
        chk("mid.fu_start", fu_start, 0);
        chk("mid.x3", x3, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        begin
            int s0;
            s0 = starts;
            repeat (6) @(negedge clk);
            chk("mid.idle_no_start", starts - s0, 0);
        end
        run("restart", 1'b1, 5, 1, 0, 0, 1'b0, 1'b0, 6, 3, 1'b0, 26, 12);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/ecc_point_ctrl.md
Name: ecc_point_ctrl

Overview:
- Sequencer directly upstream of the GF(p) arithmetic unit. It performs one elliptic-curve point operation per request in affine coordinates on y^2 = x^3 + a*x + b: point add (P1+P2) or point double (2*P1).
- It issues a fixed micro-sequence of field ops (add/sub/mul/div) to the arithmetic unit and collects each result into an internal register file.
- Field values pass through verbatim. The block is agnostic of the number domain the arithmetic unit uses.

Parameters:
- WIDTH, 32, field element width; must match the arithmetic unit.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-low
- i_start  in  1  request pulse; sampled only in IDLE
- i_dbl  in  1  1 = double P1, 0 = add P1+P2; latched with i_start
- i_x1, i_y1, i_x2, i_y2, i_a  in  WIDTH each  operands and curve coefficient a; latched with i_start
- i_inf1, i_inf2  in  1 each  operand is the point at infinity
- o_busy  out  1  high from the cycle after start until the o_done cycle, inclusive
- o_done  out  1  one-cycle completion pulse
- o_x3, o_y3  out  WIDTH each  result coordinates; held until the next o_done
- o_inf3  out  1  result is the point at infinity
- o_fu_op  out  2  0 add, 1 sub, 2 mul, 3 div (div = a/b)
- o_fu_a, o_fu_b  out  WIDTH each  field-unit operands
- o_fu_start  out  1  one-cycle op request
- i_fu_result  in  WIDTH  field-unit result
- i_fu_done  in  1  completion qualifier; used for mul/div only

Behaviour:
- Reset: state IDLE, pc 0, all register-file entries and all outputs 0. Reset mid-operation aborts immediately; the next o_fu_start comes only after a new i_start.
- Register file: 10 x WIDTH, index 4 bits: 0 x1, 1 y1, 2 x2, 3 y2, 4 a, 5 L, 6 t0, 7 t1, 8 x3, 9 y3.
- Microinstruction: {op[1:0], srcA[3:0], srcB[3:0], dst[3:0]}.
- ADD sequence (9 steps, start pc 0):
  - t0=y2-y1; t1=x2-x1; L=t0/t1
  - t0=L*L; t0=t0-x1; x3=t0-x2
  - t1=x1-x3; t1=L*t1; y3=t1-y1
- DBL sequence (12 steps, start pc 9):
  - t0=x1*x1; t1=t0+t0; t0=t1+t0; t0=t0+a
  - t1=y1+y1; L=t0/t1
  - t1=L*L; t1=t1-x1; x3=t1-x1
  - t0=x1-x3; t0=L*t0; y3=t0-y1
- FSM states: IDLE, CHECK, ISSUE, WAIT, FINISH.
- IDLE: on i_start, latch all inputs into the regfile and flags, then go to CHECK. i_start in any other state is ignored.
- CHECK (1 cycle) resolves special cases, in priority order:
  1. inf1: dbl gives inf; add gives P2 (inf3=inf2).
  2. add & inf2: result P1.
  3. add & x1==x2 & y1==y2: treated as a double (pc=9).
  4. add & x1==x2 & y1!=y2: result inf.
  5. dbl & y1==0: result inf.
  - Otherwise go to ISSUE with pc at the sequence start.
  - A special case goes straight to FINISH, with no fu traffic.
  - An inf result drives o_x3 = o_y3 = 0 and o_inf3 = 1.
- ISSUE: drive op/a/b from ROM[pc] and pulse o_fu_start.
  - add/sub complete combinationally: capture i_fu_result into dst in this cycle and advance pc; no wait.
  - mul/div: go to WAIT. i_fu_done in the ISSUE cycle is ignored.
- WAIT: hold o_fu_op, o_fu_a, o_fu_b stable, with o_fu_start 0. On the first i_fu_done=1, capture the result and advance pc.
- After the last step of a sequence, go to FINISH; otherwise return to ISSUE.
- FINISH: o_x3 <= x3, o_y3 <= y3, o_inf3 <= 0 (or the special-case values), pulse o_done, return to IDLE.
- Latency: 1 (CHECK) + 1 per add/sub + (1 + fu latency) per mul/div + 1 (FINISH).
  - Special cases: o_done 2 cycles after the start cycle.
  - A new i_start is accepted in the cycle after o_done.
- No timeout: a hung field unit leaves the block in WAIT until reset.

Decomposition:
- Shared package: field-op encodings (OP_ADD/SUB/MUL/DIV), register indices, microinstruction width, sequence start pcs and lengths.
- Sub-module ecc_point_ucode_rom: combinational pc[4:0] -> microinstruction, 21 entries.

Test Plan:
- Bench field unit: behavioural mod-p model, p=17; add/sub combinational, mul/div done 3 cycles after start. Curve a=2.
- Double (5,1) -> o_x3=6, o_y3=3, o_inf3=0; exactly 12 o_fu_start pulses.
- Add (5,1)+(6,3) -> (10,6), o_inf3=0; 9 o_fu_start pulses; o_fu_a/b stable throughout each WAIT.
- Add (5,1)+(5,16) -> o_inf3=1, o_x3=o_y3=0; o_done 2 cycles after start; no o_fu_start.
- Add (5,1)+(5,1) -> (6,3) via the DBL path.
- Double (3,0) -> inf.
- Add with inf1=1 and P2=(6,3) -> (6,3).
- Reset asserted mid-WAIT, then double (5,1): o_busy, o_done and o_fu_start drop to 0 asynchronously, and the restarted request yields (6,3).
